// File: rtl/rate_comp_pkg.sv
// Shared constants and types for the receive-side rate compensator.
//   PCS_IDLE  : all-idle control block inserted to restore the block rate
//   PCS_ERROR : error control block emitted when the FIFO runs dry
//   state_e   : controller states (fill, pass-through, idle insertion)
//   out_sel_e : source selector for the registered output block
package rate_comp_pkg;

    localparam int unsigned NB_BLOCK = 66;

    localparam logic [NB_BLOCK-1:0] PCS_IDLE  = 66'h2_1e00000000000000;
    localparam logic [NB_BLOCK-1:0] PCS_ERROR = 66'h2_1e1e1e1e1e1e1e1e;

    typedef enum logic [1:0] {
        StFill,
        StPass,
        StInsert
    } state_e;

    typedef enum logic [1:0] {
        SelIdle,
        SelError,
        SelFifo
    } out_sel_e;

endpackage

// File: rtl/rate_comp_fifo.sv
// Synchronous FIFO with registered read data and a synchronous flush.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_flush          : synchronous return of pointers and level to empty
//   i_push, i_data   : write request and data; ignored when full unless popping
//   i_pop            : read request; ignored when empty
//   o_head           : current head entry (unregistered look-ahead)
//   o_data           : registered read data, updated on each accepted pop
//   o_level          : occupancy, NB_ADDR+1 bits so full differs from empty
//   o_full, o_empty  : occupancy flags
module rate_comp_fifo #(
    parameter int unsigned NB_DATA = 66,
    parameter int unsigned NB_ADDR = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [NB_DATA-1:0] i_data,
    output logic [NB_DATA-1:0] o_head,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_ADDR:0]   o_level,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned       DEPTH    = 2 ** NB_ADDR;
    localparam logic [NB_ADDR:0]  FULL_LVL = {1'b1, {NB_ADDR{1'b0}}};

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_ADDR-1:0] wr_ptr_q;
    logic [NB_ADDR-1:0] rd_ptr_q;
    logic [NB_ADDR:0]   level_q;
    logic [NB_DATA-1:0] data_q;
    logic               do_push;
    logic               do_pop;

    assign o_full  = (level_q == FULL_LVL);
    assign o_empty = (level_q == '0);
    assign do_pop  = i_pop & ~o_empty & ~i_flush;
    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
    assign do_push = i_push & (~o_full | do_pop) & ~i_flush;

    assign o_head  = mem[rd_ptr_q];
    assign o_data  = data_q;
    assign o_level = level_q;

    always_ff @(posedge i_clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + NB_ADDR'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + NB_ADDR'(1);
                data_q   <= mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (NB_ADDR + 1)'(1);
                2'b01:   level_q <= level_q - (NB_ADDR + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rate_comp_rx.sv
// Receive-side rate compensator. Drops alignment-marker blocks from the reordered
// 66-bit stream and pays the resulting debt back by inserting idle blocks directly
// after an idle block popped from the FIFO.
//   i_clock, i_reset  : clock, asynchronous active-high reset
//   i_rf_enable       : low = synchronous flush (sticky flags hold)
//   i_valid           : one block in and one block out per valid cycle
//   i_sol_tag         : current block is an alignment marker
//   i_data / o_data   : input block / registered output block
//   o_valid           : i_valid delayed one cycle, 0 during flush
//   o_fifo_level      : FIFO occupancy
//   o_overflow, o_underflow, o_debt_sat : sticky error flags
// Optional macro RATE_COMP_STATS_EN adds o_drop_count and o_ins_count
// (16-bit saturating counts of dropped markers and inserted idles).
module rate_comp_rx
    import rate_comp_pkg::*;
#(
    parameter int unsigned NB_DATA_CODED = 66,
    parameter int unsigned N_LANES       = 20,
    parameter int unsigned NB_ADDR       = 5,
    parameter int unsigned PREFILL       = 8,
    parameter int unsigned MAX_DEBT      = 2 * N_LANES
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_rf_enable,
    input  logic                     i_valid,
    input  logic                     i_sol_tag,
    input  logic [NB_DATA_CODED-1:0] i_data,
    output logic [NB_DATA_CODED-1:0] o_data,
    output logic                     o_valid,
    output logic [NB_ADDR:0]         o_fifo_level,
    output logic                     o_overflow,
    output logic                     o_underflow,
`ifdef RATE_COMP_STATS_EN
    output logic [15:0]              o_drop_count,
    output logic [15:0]              o_ins_count,
`endif
    output logic                     o_debt_sat
);

    localparam int unsigned        NB_DEBT     = $clog2(MAX_DEBT + 1);
    localparam logic [NB_DEBT-1:0] DEBT_MAX    = NB_DEBT'(MAX_DEBT);
    localparam logic [NB_ADDR:0]   PREFILL_LVL = (NB_ADDR + 1)'(PREFILL);

    state_e                   state_q;
    out_sel_e                 out_sel_q;
    logic                     valid_q;
    logic [NB_DEBT-1:0]       debt_q;
    logic [NB_DEBT-1:0]       debt_d;
    logic                     overflow_q;
    logic                     underflow_q;
    logic                     debt_sat_q;

    logic                     active;
    logic                     push;
    logic                     drop;
    logic                     pop;
    logic                     dec;
    logic [NB_DATA_CODED-1:0] fifo_head;
    logic [NB_DATA_CODED-1:0] fifo_rd_data;
    logic [NB_ADDR:0]         fifo_level;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign active = i_valid & i_rf_enable;
    assign push   = active & ~i_sol_tag;
    assign drop   = active & i_sol_tag;
    assign pop    = active & (state_q == StPass);
    assign dec    = active & (state_q == StInsert);

    rate_comp_fifo #(
        .NB_DATA (NB_DATA_CODED),
        .NB_ADDR (NB_ADDR)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (~i_rf_enable),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (i_data),
        .o_head  (fifo_head),
        .o_data  (fifo_rd_data),
        .o_level (fifo_level),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // A drop and an insertion in the same cycle cancel; drops saturate at DEBT_MAX.
    always_comb begin
        debt_d = debt_q;
        if (drop && !dec) begin
            if (debt_q != DEBT_MAX) begin
                debt_d = debt_q + NB_DEBT'(1);
            end
        end else if (dec && !drop) begin
            debt_d = debt_q - NB_DEBT'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StFill;
            out_sel_q   <= SelIdle;
            valid_q     <= 1'b0;
            debt_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            debt_sat_q  <= 1'b0;
        end else if (!i_rf_enable) begin
            state_q   <= StFill;
            out_sel_q <= SelIdle;
            valid_q   <= 1'b0;
            debt_q    <= '0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                debt_q <= debt_d;
                // A full FIFO never blocks a push while a pop is in progress.
                if (push && fifo_full && !pop) begin
                    overflow_q <= 1'b1;
                end
                if (drop && debt_q == DEBT_MAX) begin
                    debt_sat_q <= 1'b1;
                end
                unique case (state_q)
                    StFill: begin
                        out_sel_q <= SelIdle;
                        if (fifo_level >= PREFILL_LVL) begin
                            state_q <= StPass;
                        end
                    end
                    StPass: begin
                        if (fifo_empty) begin
                            out_sel_q   <= SelError;
                            underflow_q <= 1'b1;
                            state_q     <= StFill;
                        end else begin
                            out_sel_q <= SelFifo;
                            if (fifo_head == PCS_IDLE && debt_q != '0) begin
                                state_q <= StInsert;
                            end
                        end
                    end
                    StInsert: begin
                        out_sel_q <= SelIdle;
                        if (debt_d == '0) begin
                            state_q <= StPass;
                        end
                    end
                    default: state_q <= StFill;
                endcase
            end
        end
    end

    // Both the selector and the FIFO read data are flops; this only picks between them.
    always_comb begin
        unique case (out_sel_q)
            SelFifo:  o_data = fifo_rd_data;
            SelError: o_data = PCS_ERROR;
            default:  o_data = PCS_IDLE;
        endcase
    end

    assign o_valid      = valid_q;
    assign o_fifo_level = fifo_level;
    assign o_overflow   = overflow_q;
    assign o_underflow  = underflow_q;
    assign o_debt_sat   = debt_sat_q;

`ifdef RATE_COMP_STATS_EN
    logic [15:0] drop_count_q;
    logic [15:0] ins_count_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            drop_count_q <= '0;
            ins_count_q  <= '0;
        end else if (!i_rf_enable) begin
            drop_count_q <= '0;
            ins_count_q  <= '0;
        end else begin
            if (drop && drop_count_q != '1) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (dec && ins_count_q != '1) begin
                ins_count_q <= ins_count_q + 16'd1;
            end
        end
    end

    assign o_drop_count = drop_count_q;
    assign o_ins_count  = ins_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
